// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: stall/mispredict events in, per-stage
// write-enable/flush controls, redirect and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              IM_stall;
  logic              DM_stall;
  logic              MC_busy;
  logic              ID_load_use;
  logic              EX_mispredict;
  logic [ADDR_W-1:0] EX_redirect_pc;

  logic              PC_Write;
  logic              IF_ID_Reg_Write;
  logic              IF_Flush;
  logic              ID_EX_Reg_Write;
  logic              ID_Flush;
  logic              EX_MEM_Reg_Write;
  logic              MEM_WB_Reg_Write;
  logic              PC_redirect_valid;
  logic [ADDR_W-1:0] PC_redirect_target;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;
  logic              stall_timeout;

  modport master (
    output IM_stall, DM_stall, MC_busy, ID_load_use, EX_mispredict, EX_redirect_pc,
    input  PC_Write, IF_ID_Reg_Write, IF_Flush, ID_EX_Reg_Write, ID_Flush,
           EX_MEM_Reg_Write, MEM_WB_Reg_Write, PC_redirect_valid, PC_redirect_target,
           stall_cycles, flush_count, stall_timeout
  );

  modport slave (
    input  IM_stall, DM_stall, MC_busy, ID_load_use, EX_mispredict, EX_redirect_pc,
    output PC_Write, IF_ID_Reg_Write, IF_Flush, ID_EX_Reg_Write, ID_Flush,
           EX_MEM_Reg_Write, MEM_WB_Reg_Write, PC_redirect_valid, PC_redirect_target,
           stall_cycles, flush_count, stall_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; defers a mispredict
// redirect that arrives during a freeze, and keeps stall counters and a watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned FC_W = $clog2(MAX_STALL + 1);

  typedef enum logic {
    RUN,
    FLUSH_PEND
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [FC_W-1:0]   freeze_cnt_q, freeze_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              stall_timeout_q, stall_timeout_d;

  logic              freeze;
  logic              pc_write;
  logic              if_id_write;
  logic              if_flush;
  logic              id_ex_write;
  logic              id_flush;
  logic              ex_mem_write;
  logic              mem_wb_write;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;

  assign freeze = bus.IM_stall | bus.DM_stall | bus.MC_busy;

  // Next-state and control outputs; any freeze dominates every other event.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_flush      = 1'b0;
    id_ex_write   = 1'b1;
    id_flush      = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    redir_valid   = 1'b0;
    redir_target  = '0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if (bus.EX_mispredict) begin
              pend_target_d = bus.EX_redirect_pc;
              state_d       = FLUSH_PEND;
            end
          end else if (bus.EX_mispredict) begin
            if_flush     = 1'b1;
            id_flush     = 1'b1;
            redir_valid  = 1'b1;
            redir_target = bus.EX_redirect_pc;
          end else if (bus.ID_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_flush    = 1'b1;
          end
        end
        FLUSH_PEND: begin
          if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
          end else begin
            if_flush     = 1'b1;
            id_flush     = 1'b1;
            redir_valid  = 1'b1;
            redir_target = pend_target_q;
            state_d      = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Performance counters and freeze watchdog.
  always_comb begin
    stall_cycles_d  = stall_cycles_q + (pc_write ? CNT_W'(0) : CNT_W'(1));
    flush_count_d   = flush_count_q + (redir_valid ? CNT_W'(1) : CNT_W'(0));
    freeze_cnt_d    = '0;
    stall_timeout_d = stall_timeout_q;
    if (freeze) begin
      freeze_cnt_d = (freeze_cnt_q == FC_W'(MAX_STALL)) ? freeze_cnt_q
                                                        : freeze_cnt_q + FC_W'(1);
      if (freeze_cnt_q >= FC_W'(MAX_STALL - 1)) begin
        stall_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      pend_target_q   <= '0;
      freeze_cnt_q    <= '0;
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_target_q   <= pend_target_d;
      freeze_cnt_q    <= freeze_cnt_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_count_q   <= flush_count_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign bus.PC_Write           = pc_write;
  assign bus.IF_ID_Reg_Write    = if_id_write;
  assign bus.IF_Flush           = if_flush;
  assign bus.ID_EX_Reg_Write    = id_ex_write;
  assign bus.ID_Flush           = id_flush;
  assign bus.EX_MEM_Reg_Write   = ex_mem_write;
  assign bus.MEM_WB_Reg_Write   = mem_wb_write;
  assign bus.PC_redirect_valid  = redir_valid;
  assign bus.PC_redirect_target = redir_target;
  assign bus.stall_cycles       = stall_cycles_q;
  assign bus.flush_count        = flush_count_q;
  assign bus.stall_timeout      = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized events, every cycle
// compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned MAX_STALL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model state: values the registers hold after the next clock edge.
  bit              m_pending;
  logic [31:0]     m_pend_tgt;
  logic [31:0]     m_stalls;
  logic [31:0]     m_flushes;
  int              m_run;
  bit              m_timeout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare every output with the model, advance the model.
  task automatic step(input bit r, input bit im, input bit dm, input bit mc,
                      input bit lu, input bit mp, input logic [31:0] pc);
    bit frz, e_pcw, e_ifid, e_iff, e_idex, e_idf, e_late, e_v;
    logic [31:0] e_tgt;
    @(negedge clk);
    rst                = r;
    bus.IM_stall       = im;
    bus.DM_stall       = dm;
    bus.MC_busy        = mc;
    bus.ID_load_use    = lu;
    bus.EX_mispredict  = mp;
    bus.EX_redirect_pc = pc;
    #1;
    frz   = im | dm | mc;
    e_pcw = 1; e_ifid = 1; e_iff = 0; e_idex = 1; e_idf = 0; e_late = 1; e_v = 0;
    e_tgt = 32'h0;
    if (!r) begin
      if (frz) begin
        e_pcw = 0; e_ifid = 0; e_idex = 0; e_late = 0;
      end else if (m_pending || mp) begin
        e_iff = 1; e_idf = 1; e_v = 1;
        e_tgt = m_pending ? m_pend_tgt : pc;
      end else if (lu) begin
        e_pcw = 0; e_ifid = 0; e_idf = 1;
      end
    end
    check("PC_Write",          bus.PC_Write,          e_pcw);
    check("IF_ID_Reg_Write",   bus.IF_ID_Reg_Write,   e_ifid);
    check("IF_Flush",          bus.IF_Flush,          e_iff);
    check("ID_EX_Reg_Write",   bus.ID_EX_Reg_Write,   e_idex);
    check("ID_Flush",          bus.ID_Flush,          e_idf);
    check("EX_MEM_Reg_Write",  bus.EX_MEM_Reg_Write,  e_late);
    check("MEM_WB_Reg_Write",  bus.MEM_WB_Reg_Write,  e_late);
    check("PC_redirect_valid", bus.PC_redirect_valid, e_v);
    if (e_v || r) check("PC_redirect_target", bus.PC_redirect_target, e_tgt);
    if (!r) begin
      check("stall_cycles",  bus.stall_cycles,  m_stalls);
      check("flush_count",   bus.flush_count,   m_flushes);
      check("stall_timeout", bus.stall_timeout, m_timeout);
    end
    if (r) begin
      m_pending = 0; m_pend_tgt = 0; m_stalls = 0; m_flushes = 0; m_run = 0; m_timeout = 0;
    end else begin
      if (!e_pcw) m_stalls++;
      if (e_v) m_flushes++;
      if (frz) begin
        if (!m_pending && mp) begin
          m_pending  = 1;
          m_pend_tgt = pc;
        end
        m_run++;
        if (m_run >= int'(MAX_STALL)) m_timeout = 1;
      end else begin
        m_pending = 0;
        m_run     = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    bus.IM_stall = 0; bus.DM_stall = 0; bus.MC_busy = 0;
    bus.ID_load_use = 0; bus.EX_mispredict = 0; bus.EX_redirect_pc = '0;

    // Idle after reset
    do_reset();
    idle(20);
    check("idle stall_cycles", bus.stall_cycles, 64'd0);
    check("idle flush_count",  bus.flush_count,  64'd0);

    // Single load-use bubble
    do_reset();
    step(0, 0, 0, 0, 1, 0, 32'h0);
    check("lu PC_Write", bus.PC_Write, 64'd0);
    check("lu ID_Flush", bus.ID_Flush, 64'd1);
    idle(1);
    check("lu stall_cycles", bus.stall_cycles, 64'd1);

    // Immediate mispredict
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    check("mp target",   bus.PC_redirect_target, 64'h100);
    check("mp IF_Flush", bus.IF_Flush, 64'd1);
    idle(1);
    check("mp flush_count", bus.flush_count, 64'd1);

    // Mispredict held across a data-memory freeze
    do_reset();
    step(0, 0, 1, 0, 0, 1, 32'h200);
    step(0, 0, 1, 0, 0, 1, 32'h300);
    step(0, 0, 1, 0, 0, 0, 32'h300);
    check("frz MEM_WB_Reg_Write", bus.MEM_WB_Reg_Write, 64'd0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    check("pend valid",  bus.PC_redirect_valid, 64'd1);
    check("pend target", bus.PC_redirect_target, 64'h200);
    idle(1);
    check("pend once",         bus.PC_redirect_valid, 64'd0);
    check("pend flush_count",  bus.flush_count, 64'd1);
    check("pend stall_cycles", bus.stall_cycles, 64'd3);

    // Mispredict beats load-use
    do_reset();
    step(0, 0, 0, 0, 1, 1, 32'h440);
    check("prio PC_Write", bus.PC_Write, 64'd1);
    check("prio IF_Flush", bus.IF_Flush, 64'd1);

    // Watchdog with MAX_STALL=4
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 0, 0, 0, 0, 32'h0);
      if (i == 4) check("wd before", bus.stall_timeout, 64'd0);
      if (i == 5) check("wd set",    bus.stall_timeout, 64'd1);
    end
    idle(3);
    check("wd sticky",       bus.stall_timeout, 64'd1);
    check("wd stall_cycles", bus.stall_cycles,  64'd6);

    // Reset while a redirect is pending discards it
    step(0, 0, 1, 0, 0, 1, 32'h400);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    check("rst no redirect",  bus.PC_redirect_valid, 64'd0);
    check("rst stall_cycles", bus.stall_cycles, 64'd0);
    check("rst flush_count",  bus.flush_count,  64'd0);
    check("rst timeout",      bus.stall_timeout, 64'd0);

    // Randomized event mix
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(299) == 0),
           ($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(9) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
